// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes, transmitter state encoding and frame sizing.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Total bits on the line for one frame, start bit included.
    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Producer-side handshake of the UART transmitter: request, word and idle indication.
interface uart_tx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 en;
    logic [DATA_BITS-1:0] data_tx;
    logic                 rdy;

    modport master (output en, output data_tx, input rdy);
    modport slave  (input en, input data_tx, output rdy);
endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period divider shared by the UART transmitter and receiver; bit_end marks the last cycle of a bit.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_end
);

    localparam int               CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_end = (cnt == LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start, DATA_BITS data bits LSB first, optional parity, 1-2 stop bits.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_cfg_if.slave    bus,
    output logic            dout
);

    localparam int               IDX_W     = $clog2(DATA_BITS) + 1;
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
    localparam int               FRAME_LEN = frame_bits(DATA_BITS, PARITY, STOP_BITS);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $fatal(1, "uart_tx_cfg: CLKS_PER_BIT must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $fatal(1, "uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_bad_par
        $fatal(1, "uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $fatal(1, "uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (FRAME_LEN > 13) begin : g_bad_frame
        $fatal(1, "uart_tx_cfg: frame longer than 13 bits");
    end

    tx_state_e            state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 dout_d;
    logic                 rdy_q;
    logic                 bit_end;

    // The divider is held at zero while idle so every frame starts on a fresh bit period.
    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q == ST_IDLE),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            dout    <= 1'b1;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dout    <= dout_d;
            rdy_q   <= (state_d == ST_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
        par_q   <= par_d;
    end

    assign bus.rdy = rdy_q;

    // dout is registered from the next-state view so each level lines up with its state.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        dout_d  = dout;
        unique case (state_q)
            ST_IDLE: begin
                dout_d = 1'b1;
                if (bus.en) begin
                    state_d = ST_START;
                    shreg_d = bus.data_tx;
                    par_d   = (PARITY == PARITY_EVEN) ? (^bus.data_tx) : ~(^bus.data_tx);
                    idx_d   = '0;
                    dout_d  = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    dout_d  = shreg_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (idx_q == LAST_DATA) begin
                        idx_d = '0;
                        if (PARITY != PARITY_NONE) begin
                            state_d = ST_PARITY;
                            dout_d  = par_q;
                        end else begin
                            state_d = ST_STOP;
                            dout_d  = 1'b1;
                        end
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        dout_d = shreg_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    dout_d  = 1'b1;
                end
            end
            ST_STOP: begin
                dout_d = 1'b1;
                if (bit_end) begin
                    if (idx_q == LAST_STOP) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                dout_d  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: 8N1, 8E1, 8O1 and 7N2 instances at four clocks per bit.
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] en_v;
    logic [7:0] dat_v [4];
    logic [3:0] dout_v;
    logic [3:0] rdy_v;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_tx_cfg_if #(.DATA_BITS(8)) bus0 ();
    uart_tx_cfg_if #(.DATA_BITS(8)) bus1 ();
    uart_tx_cfg_if #(.DATA_BITS(8)) bus2 ();
    uart_tx_cfg_if #(.DATA_BITS(7)) bus3 ();

    assign bus0.en = en_v[0];
    assign bus1.en = en_v[1];
    assign bus2.en = en_v[2];
    assign bus3.en = en_v[3];
    assign bus0.data_tx = dat_v[0];
    assign bus1.data_tx = dat_v[1];
    assign bus2.data_tx = dat_v[2];
    assign bus3.data_tx = dat_v[3][6:0];
    assign rdy_v = {bus3.rdy, bus2.rdy, bus1.rdy, bus0.rdy};

    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .bus(bus0.slave), .dout(dout_v[0]));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .bus(bus1.slave), .dout(dout_v[1]));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .bus(bus2.slave), .dout(dout_v[2]));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .rst(rst), .bus(bus3.slave), .dout(dout_v[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] low_mask(input int n);
        return (32'd1 << n) - 32'd1;
    endfunction

    // Sends one word on instance sel; bits[b] is dout sampled mid-bit b, low counts rdy=0
    // cycles, rise is the cycle offset from the accept edge at which rdy is seen high again.
    task automatic run_frame(input int sel, input logic [7:0] d, input int nbits, input bit pulse,
                             output logic [31:0] bits, output int low, output int rise);
        bits = '1;
        low  = 0;
        rise = 0;
        @(negedge clk);
        dat_v[sel] = d;
        en_v[sel]  = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 200 && rise == 0; i++) begin
            @(negedge clk);
            if (i == 1) begin
                en_v[sel]  = 1'b0;
                dat_v[sel] = ~d;
            end
            if (pulse && i >= 10 && i < 13) en_v[sel] = 1'b1;
            if (pulse && i == 13) en_v[sel] = 1'b0;
            if (rdy_v[sel]) rise = i;
            else low++;
            if ((i - 1) % 4 == 2 && (i - 1) / 4 < nbits) bits[(i - 1) / 4] = dout_v[sel];
        end
    endtask

    logic [31:0] bits, f1, f2;
    int          low, rise, low2;
    logic        gap_dout, gap_rdy, st_dout, end_rdy, idle_ok;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        en_v = '0;
        for (int k = 0; k < 4; k++) dat_v[k] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_dout", 32'(dout_v), 32'hF);
        check("reset_rdy",  32'(rdy_v),  32'hF);
        rst = 1'b0;

        run_frame(0, 8'hAA, 10, 1'b0, bits, low, rise);
        check("8n1_bits", bits & low_mask(10), 32'({1'b1, 8'hAA, 1'b0}));
        check("8n1_low",  32'(low),  32'd40);
        check("8n1_rise", 32'(rise), 32'd41);

        run_frame(1, 8'hAA, 11, 1'b0, bits, low, rise);
        check("8e1_bits", bits & low_mask(11), 32'({1'b1, 1'b0, 8'hAA, 1'b0}));
        check("8e1_low",  32'(low),  32'd44);
        check("8e1_rise", 32'(rise), 32'd45);

        run_frame(2, 8'hAA, 11, 1'b0, bits, low, rise);
        check("8o1_bits", bits & low_mask(11), 32'({1'b1, 1'b1, 8'hAA, 1'b0}));
        check("8o1_low",  32'(low),  32'd44);

        run_frame(1, 8'h01, 11, 1'b0, bits, low, rise);
        check("8e1_01_bits", bits & low_mask(11), 32'({1'b1, 1'b1, 8'h01, 1'b0}));

        run_frame(3, 8'h55, 10, 1'b0, bits, low, rise);
        check("7n2_bits", bits & low_mask(10), 32'({1'b1, 1'b1, 7'h55, 1'b0}));
        check("7n2_low",  32'(low),  32'd40);
        check("7n2_rise", 32'(rise), 32'd41);

        // Requests while busy must neither disturb the frame nor queue another one.
        run_frame(0, 8'hC3, 10, 1'b1, bits, low, rise);
        check("ignore_bits", bits & low_mask(10), 32'({1'b1, 8'hC3, 1'b0}));
        check("ignore_low",  32'(low), 32'd40);
        idle_ok = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (dout_v[0] !== 1'b1 || rdy_v[0] !== 1'b1) idle_ok = 1'b0;
        end
        check("no_queued_frame", 32'(idle_ok), 32'd1);

        // Back-to-back with en held high; data changes right after each acceptance.
        f1 = '1;
        f2 = '1;
        low2 = 0;
        gap_dout = 1'b0;
        gap_rdy  = 1'b0;
        st_dout  = 1'b1;
        end_rdy  = 1'b0;
        @(negedge clk);
        dat_v[0] = 8'h00;
        en_v[0]  = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 82; i++) begin
            @(negedge clk);
            if (i == 1) dat_v[0] = 8'hFF;
            if (i == 43) dat_v[0] = 8'h5A;
            if (i == 81) en_v[0] = 1'b0;
            if ((i - 1) % 4 == 2 && i < 41) f1[(i - 1) / 4] = dout_v[0];
            if (i >= 42 && (i - 42) % 4 == 2 && i < 82) f2[(i - 42) / 4] = dout_v[0];
            if (i == 41) begin
                gap_dout = dout_v[0];
                gap_rdy  = rdy_v[0];
            end
            if (i == 42) st_dout = dout_v[0];
            if (i >= 42 && i < 82 && !rdy_v[0]) low2++;
            if (i == 82) end_rdy = rdy_v[0];
        end
        check("b2b_frame1", f1 & low_mask(10), 32'({1'b1, 8'h00, 1'b0}));
        check("b2b_gap_dout", 32'(gap_dout), 32'd1);
        check("b2b_gap_rdy",  32'(gap_rdy),  32'd1);
        check("b2b_start2",   32'(st_dout),  32'd0);
        check("b2b_frame2", f2 & low_mask(10), 32'({1'b1, 8'hFF, 1'b0}));
        check("b2b_low2",     32'(low2),     32'd40);
        check("b2b_end_rdy",  32'(end_rdy),  32'd1);

        // Reset during data bit 3 (line low for data 0x00), then a clean frame.
        repeat (2) @(negedge clk);
        dat_v[0] = 8'h00;
        en_v[0]  = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (i == 1) en_v[0] = 1'b0;
        end
        check("mid_bit3_dout", 32'(dout_v[0]), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_dout", 32'(dout_v[0]), 32'd1);
        check("abort_rdy",  32'(rdy_v[0]),  32'd1);
        run_frame(0, 8'h3C, 10, 1'b0, bits, low, rise);
        check("post_rst_bits", bits & low_mask(10), 32'({1'b1, 8'h3C, 1'b0}));
        check("post_rst_low",  32'(low), 32'd40);

        // rst and en together: request dropped.
        @(negedge clk);
        dat_v[0] = 8'h00;
        en_v[0]  = 1'b1;
        rst      = 1'b1;
        @(negedge clk);
        en_v[0] = 1'b0;
        rst     = 1'b0;
        check("prio_rdy", 32'(rdy_v[0]), 32'd1);
        idle_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (dout_v[0] !== 1'b1) idle_ok = 1'b0;
            @(negedge clk);
        end
        check("prio_dout_high", 32'(idle_ok), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter that serialises one data word per handshake onto a single idle-high line. It supports configurable baud divisor, word length, parity mode and stop-bit count. It replaces the fixed 8N1 transmitter in designs that need other framings, and sits between a byte/word producer and the board TX pin. Per-frame behaviour is unchanged from the 8N1 generation when the defaults are used.

## Interface
Parameters:
- CLKS_PER_BIT, default 10416: clock cycles per bit. Must be ≥ 2. The default gives 9600 baud at 100 MHz.
- DATA_BITS, default 8: data bits per frame. Legal range 5..9.
- PARITY, default 0: parity mode. 0 = none, 1 = odd, 2 = even.
- STOP_BITS, default 1: number of stop bits. Legal values 1 or 2.

Ports (one clock; reset is synchronous and active-high):
- clk, input, 1: system clock. Everything is on the rising edge.
- rst, input, 1: synchronous active-high reset.
- en, input, 1: transmit request. Sampled only while rdy = 1.
- data_tx, input, DATA_BITS: word to send. Sampled in the same cycle as an accepted en.
- rdy, output, 1: transmitter idle and able to accept en.
- dout, output, 1: serial line. Registered, idle high.

## Operation
- **States:** IDLE → START → DATA → PARITY → STOP → IDLE. PARITY is skipped when PARITY = 0.
- **Accept:** en = 1 while in IDLE (rdy = 1) accepts a request.
  - data_tx is latched into a shift register.
  - Parity bit is computed at latch time: even → XOR of the data bits; odd → its inverse.
  - Baud counter is cleared and bit index is set to 0.
  - en while rdy = 0 is ignored; no queuing.
- **Bit levels:**
  - START drives 0.
  - DATA drives bits LSB first, one per bit period, with index 0..DATA_BITS-1.
  - PARITY drives the latched parity bit.
  - STOP drives 1 for STOP_BITS bit periods.
- **Baud counter:** counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). A bit ends when the counter reaches CLKS_PER_BIT-1; the counter then wraps to 0.
- **Bit index:** width $clog2(DATA_BITS)+1. It advances only at a bit end in DATA and in STOP.
- **rdy:** registered, equal to (next state == IDLE).
- **Source stability:** data_tx changes after acceptance do not affect the frame in flight.
- **Reset values:** dout = 1, rdy = 1, state = IDLE, counters = 0.
- **Reset mid-frame:** the frame is aborted. dout = 1 and rdy = 1 in the cycle after rst is sampled high. No partial stop bit is emitted.
- **Simultaneous rst and en:** rst wins and the request is dropped.

## Timing
- **Start of frame:** en accepted at edge N → dout = 0 and rdy = 0 from edge N+1.
- **Frame length:** F = CLKS_PER_BIT × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) cycles of rdy = 0.
- **Line return:** dout returns to 1 at the start of the first stop bit and stays 1 through idle.
- **End of frame:** rdy rises at edge N+1+F.
- **Back-to-back:** en held high at that edge starts the next start bit at N+2+F. The minimum inter-frame gap is exactly one cycle of idle-high.
- **Bit boundaries:** each lasts exactly CLKS_PER_BIT cycles with no drift across the frame.

## Structure
- Shared package uart_pkg holds:
  - the PARITY_NONE, PARITY_ODD and PARITY_EVEN constants;
  - the tx state enum;
  - a helper function that returns the frame length in bits.
- The baud divider is its own sub-module, uart_baud_cnt.
  - Inputs: clk, rst, clr. Output: a one-cycle bit_end pulse.
  - Parameter: CLKS_PER_BIT.
  - The same sub-module is reused by the future receiver.
- Parameter legality is checked at elaboration; an illegal value is a fatal error.

## Test plan
- **Default framing:** CLKS_PER_BIT=4, 8N1; en=1 with data_tx=8'hAA.
  - dout per 4-cycle bit must read 0,0,1,0,1,0,1,0,1,1.
  - rdy must be low for exactly 40 cycles.
  - rdy must rise at edge N+41.
- **Parity:** CLKS_PER_BIT=4, DATA_BITS=8, data_tx=8'hAA.
  - PARITY=2 (even): parity bit = 0.
  - PARITY=1 (odd): parity bit = 1.
  - data 8'h01 with even parity: parity bit = 1.
  - Frame length 44 cycles.
- **Short word, two stop bits:** DATA_BITS=7, STOP_BITS=2, PARITY=0, data_tx=7'h55.
  - Bits must read 0,1,0,1,0,1,0,1,1,1.
  - rdy low for 40 cycles.
- **Back-to-back and ignored requests:** en held high continuously, data_tx stepping through 8'h00, 8'hFF.
  - Exactly one idle-high cycle between frames.
  - en pulses during a frame cause no effect and no queued frame.
- **Reset:**
  - rst asserted mid-DATA on bit 3: dout = 1 and rdy = 1 the next cycle.
  - A subsequent en sends a complete, correct frame.
- **Reset priority:** rst and en high in the same cycle → no frame starts, dout stays 1.
